// File: rtl/axi_dma_seq_pkg.sv
// Shared definitions for the AXI DMA block sequencer.
//   dma_state_e    : per-channel FSM encoding (3 bits, ST_IDLE..ST_DONE)
//   DMA_BLK_SHIFT  : default log2(bytes per block)
package axi_dma_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_SYNC = 3'd3,
    ST_DONE = 3'd4
  } dma_state_e;

  localparam int unsigned DMA_BLK_SHIFT = 6;

endpackage

// File: rtl/dma_seq_chan.sv
// One DMA sequencer channel: request FSM, block counter, busy/done.
// TWO_D=1 (read side) adds a row counter and a row-base accumulator, so the
// address walks rows x blocks with a programmable stride and no multiplier.
// TWO_D=0 (write side) adds the per-word data counter within each burst.
// Optional macro DMA_SEQ_PERF_EN enables the busy-cycle counter on cycles_o;
// without it cycles_o is tied to 0.
// Ports:
//   clk, rst       clock, async active-high reset
//   start_i        start pulse, accepted only in IDLE (latches all config)
//   base_i         region base byte address
//   blks_i         blocks per row (2-D) or total blocks (linear)
//   rows_i         row count (2-D only)
//   stride_i       byte distance between row starts (2-D only)
//   num_trans_i    words per burst (linear only; 0 behaves as 1)
//   xfer_done_i    master burst-complete pulse, honoured only in WAIT
//   word_req_i     master consumed one word (linear only, honoured in WAIT)
//   req_o          block request pulse
//   addr_o         block address (2-D) / current word address (linear)
//   data_cnt_o     word index within the current burst (0 for 2-D)
//   busy_o/done_o  channel active / 1-cycle completion pulse
//   cycles_o       busy-cycle count
module dma_seq_chan
  import axi_dma_seq_pkg::*;
#(
  parameter int unsigned AXI_WIDTH_AD = 32,
  parameter int unsigned BIT_TRANS    = 18,
  parameter int unsigned BIT_BLK      = 16,
  parameter int unsigned BIT_ROW      = 11,
  parameter int unsigned BLK_SHIFT    = DMA_BLK_SHIFT,
  parameter bit          TWO_D        = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [AXI_WIDTH_AD-1:0] base_i,
  input  logic [BIT_BLK-1:0]      blks_i,
  input  logic [BIT_ROW-1:0]      rows_i,
  input  logic [AXI_WIDTH_AD-1:0] stride_i,
  input  logic [BIT_TRANS-1:0]    num_trans_i,
  input  logic                    xfer_done_i,
  input  logic                    word_req_i,
  output logic                    req_o,
  output logic [AXI_WIDTH_AD-1:0] addr_o,
  output logic [BIT_TRANS-1:0]    data_cnt_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [31:0]             cycles_o
);

  dma_state_e state_q, state_d;

  logic [AXI_WIDTH_AD-1:0] base_q;
  logic [AXI_WIDTH_AD-1:0] row_base;
  logic [BIT_BLK-1:0]      blks_q;
  logic [BIT_BLK-1:0]      blk_idx_q;
  logic                    accept;
  logic                    zero_len;
  logic                    blk_wrap;
  logic                    last_blk;
  logic                    advance;

  assign accept  = (state_q == ST_IDLE) && start_i;
  // Step to the next block only on a non-final burst completion.
  assign advance = (state_q == ST_WAIT) && xfer_done_i && !last_blk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = zero_len ? ST_DONE : ST_REQ;
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: if (xfer_done_i) state_d = last_blk ? ST_DONE : ST_SYNC;
      ST_SYNC: state_d = ST_REQ;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_o  = (state_q == ST_REQ);
  assign done_o = (state_q == ST_DONE);
  assign busy_o = (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q    <= '0;
      blks_q    <= '0;
      blk_idx_q <= '0;
    end else if (accept) begin
      base_q    <= base_i;
      blks_q    <= blks_i;
      blk_idx_q <= '0;
    end else if (advance) begin
      blk_idx_q <= blk_wrap ? '0 : blk_idx_q + BIT_BLK'(1);
    end
  end

  assign addr_o = base_q + row_base
                + (AXI_WIDTH_AD'(blk_idx_q) << BLK_SHIFT)
                + (AXI_WIDTH_AD'(data_cnt_o) << 2);

  if (TWO_D) begin : g_rows
    logic [BIT_ROW-1:0]      rows_q;
    logic [BIT_ROW-1:0]      row_idx_q;
    logic [AXI_WIDTH_AD-1:0] stride_q;
    logic [AXI_WIDTH_AD-1:0] row_base_q;
    logic                    unused_lin;

    assign unused_lin = ^{num_trans_i, word_req_i};
    assign zero_len   = (rows_i == '0) || (blks_i == '0);
    assign blk_wrap   = (blk_idx_q == blks_q - BIT_BLK'(1));
    assign last_blk   = blk_wrap && (row_idx_q == rows_q - BIT_ROW'(1));
    assign row_base   = row_base_q;
    assign data_cnt_o = '0;

    // Row start is accumulated on each row wrap instead of row_idx*stride.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rows_q     <= '0;
        row_idx_q  <= '0;
        stride_q   <= '0;
        row_base_q <= '0;
      end else if (accept) begin
        rows_q     <= rows_i;
        stride_q   <= stride_i;
        row_idx_q  <= '0;
        row_base_q <= '0;
      end else if (advance && blk_wrap) begin
        row_idx_q  <= row_idx_q + BIT_ROW'(1);
        row_base_q <= row_base_q + stride_q;
      end
    end
  end else begin : g_lin
    logic [BIT_TRANS-1:0] num_trans_q;
    logic [BIT_TRANS-1:0] data_cnt_q;
    logic [BIT_TRANS-1:0] cnt_last;
    logic                 unused_rows;

    assign unused_rows = ^{rows_i, stride_i};
    assign zero_len    = (blks_i == '0);
    assign blk_wrap    = 1'b0;
    assign last_blk    = (blk_idx_q == blks_q - BIT_BLK'(1));
    assign row_base    = '0;
    // A zero burst length is treated as a single-word burst.
    assign cnt_last    = (num_trans_q == '0) ? '0 : num_trans_q - BIT_TRANS'(1);
    assign data_cnt_o  = data_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        num_trans_q <= '0;
        data_cnt_q  <= '0;
      end else begin
        if (accept) num_trans_q <= num_trans_i;
        if (accept || state_q == ST_REQ) begin
          data_cnt_q <= '0;
        end else if (state_q == ST_WAIT && word_req_i) begin
          data_cnt_q <= (data_cnt_q == cnt_last) ? '0 : data_cnt_q + BIT_TRANS'(1);
        end
      end
    end
  end

`ifdef DMA_SEQ_PERF_EN
  logic [31:0] cycles_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cycles_q <= '0;
    else if (accept) cycles_q <= '0;
    else if (busy_o) cycles_q <= cycles_q + 32'd1;
  end

  assign cycles_o = cycles_q;
`else
  assign cycles_o = '0;
`endif

endmodule

// File: rtl/axi_dma_seq2d.sv
// DMA sequencer between the engine control registers and the AXI DMA masters.
// Read side walks a 2-D region (rows x blocks-per-row, programmable stride);
// write side walks a linear run of blocks with a per-word address and count.
// Both sides are independent dma_seq_chan instances.
// Optional macro DMA_SEQ_PERF_EN enables o_rd_cycles/o_wr_cycles busy counters;
// otherwise both ports read 0.
// Ports:
//   clk, rst                            clock, async active-high reset
//   i_start_rd / i_start_wr             start pulses (sampled only in IDLE)
//   i_base_address_rd/_wr               region base byte addresses
//   i_num_trans                         words per write burst
//   i_rd_blks_per_row, i_rd_num_rows    read region shape
//   i_rd_row_stride                     byte distance between read rows
//   i_wr_num_blks                       write block count
//   i_read_done / i_write_done          master burst-complete pulses
//   i_indata_req_wr                     write master consumed one word
//   o_ctrl_read / o_ctrl_write          request pulses
//   o_read_addr / o_write_addr          read block / write word address
//   o_write_data_cnt                    word index within write burst
//   o_rd_busy, o_rd_done, o_wr_busy, o_wr_done   status
//   o_rd_cycles / o_wr_cycles           busy-cycle counters
module axi_dma_seq2d
  import axi_dma_seq_pkg::*;
#(
  parameter int unsigned AXI_WIDTH_AD = 32,
  parameter int unsigned BIT_TRANS    = 18,
  parameter int unsigned BIT_BLK      = 16,
  parameter int unsigned BIT_ROW      = 11,
  parameter int unsigned BLK_SHIFT    = DMA_BLK_SHIFT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start_rd,
  input  logic                    i_start_wr,
  input  logic [AXI_WIDTH_AD-1:0] i_base_address_rd,
  input  logic [AXI_WIDTH_AD-1:0] i_base_address_wr,
  input  logic [BIT_TRANS-1:0]    i_num_trans,
  input  logic [BIT_BLK-1:0]      i_rd_blks_per_row,
  input  logic [BIT_ROW-1:0]      i_rd_num_rows,
  input  logic [AXI_WIDTH_AD-1:0] i_rd_row_stride,
  input  logic [BIT_BLK-1:0]      i_wr_num_blks,
  input  logic                    i_read_done,
  output logic                    o_ctrl_read,
  output logic [AXI_WIDTH_AD-1:0] o_read_addr,
  output logic                    o_rd_busy,
  output logic                    o_rd_done,
  input  logic                    i_write_done,
  input  logic                    i_indata_req_wr,
  output logic                    o_ctrl_write,
  output logic [AXI_WIDTH_AD-1:0] o_write_addr,
  output logic [BIT_TRANS-1:0]    o_write_data_cnt,
  output logic                    o_wr_busy,
  output logic                    o_wr_done,
  output logic [31:0]             o_rd_cycles,
  output logic [31:0]             o_wr_cycles
);

  logic [BIT_TRANS-1:0] unused_rd_cnt;

  dma_seq_chan #(
    .AXI_WIDTH_AD (AXI_WIDTH_AD),
    .BIT_TRANS    (BIT_TRANS),
    .BIT_BLK      (BIT_BLK),
    .BIT_ROW      (BIT_ROW),
    .BLK_SHIFT    (BLK_SHIFT),
    .TWO_D        (1'b1)
  ) u_rd (
    .clk         (clk),
    .rst         (rst),
    .start_i     (i_start_rd),
    .base_i      (i_base_address_rd),
    .blks_i      (i_rd_blks_per_row),
    .rows_i      (i_rd_num_rows),
    .stride_i    (i_rd_row_stride),
    .num_trans_i ('0),
    .xfer_done_i (i_read_done),
    .word_req_i  (1'b0),
    .req_o       (o_ctrl_read),
    .addr_o      (o_read_addr),
    .data_cnt_o  (unused_rd_cnt),
    .busy_o      (o_rd_busy),
    .done_o      (o_rd_done),
    .cycles_o    (o_rd_cycles)
  );

  dma_seq_chan #(
    .AXI_WIDTH_AD (AXI_WIDTH_AD),
    .BIT_TRANS    (BIT_TRANS),
    .BIT_BLK      (BIT_BLK),
    .BIT_ROW      (BIT_ROW),
    .BLK_SHIFT    (BLK_SHIFT),
    .TWO_D        (1'b0)
  ) u_wr (
    .clk         (clk),
    .rst         (rst),
    .start_i     (i_start_wr),
    .base_i      (i_base_address_wr),
    .blks_i      (i_wr_num_blks),
    .rows_i      ('0),
    .stride_i    ('0),
    .num_trans_i (i_num_trans),
    .xfer_done_i (i_write_done),
    .word_req_i  (i_indata_req_wr),
    .req_o       (o_ctrl_write),
    .addr_o      (o_write_addr),
    .data_cnt_o  (o_write_data_cnt),
    .busy_o      (o_wr_busy),
    .done_o      (o_wr_done),
    .cycles_o    (o_wr_cycles)
  );

endmodule

// File: tb/tb_axi_dma_seq2d.sv
`timescale 1ns/1ps
module tb_axi_dma_seq2d;
  localparam int RD_LAT = 5;
  localparam int BUDGET = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start_rd, i_start_wr;
  logic [31:0] i_base_address_rd, i_base_address_wr;
  logic [17:0] i_num_trans;
  logic [15:0] i_rd_blks_per_row;
  logic [10:0] i_rd_num_rows;
  logic [31:0] i_rd_row_stride;
  logic [15:0] i_wr_num_blks;
  logic        i_read_done, i_write_done, i_indata_req_wr;
  logic        o_ctrl_read, o_rd_busy, o_rd_done;
  logic [31:0] o_read_addr;
  logic        o_ctrl_write, o_wr_busy, o_wr_done;
  logic [31:0] o_write_addr;
  logic [17:0] o_write_data_cnt;
  logic [31:0] o_rd_cycles, o_wr_cycles;

  always #5 clk = ~clk;

  axi_dma_seq2d #(
    .AXI_WIDTH_AD (32),
    .BIT_TRANS    (18),
    .BIT_BLK      (16),
    .BIT_ROW      (11),
    .BLK_SHIFT    (6)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_start_rd        (i_start_rd),
    .i_start_wr        (i_start_wr),
    .i_base_address_rd (i_base_address_rd),
    .i_base_address_wr (i_base_address_wr),
    .i_num_trans       (i_num_trans),
    .i_rd_blks_per_row (i_rd_blks_per_row),
    .i_rd_num_rows     (i_rd_num_rows),
    .i_rd_row_stride   (i_rd_row_stride),
    .i_wr_num_blks     (i_wr_num_blks),
    .i_read_done       (i_read_done),
    .o_ctrl_read       (o_ctrl_read),
    .o_read_addr       (o_read_addr),
    .o_rd_busy         (o_rd_busy),
    .o_rd_done         (o_rd_done),
    .i_write_done      (i_write_done),
    .i_indata_req_wr   (i_indata_req_wr),
    .o_ctrl_write      (o_ctrl_write),
    .o_write_addr      (o_write_addr),
    .o_write_data_cnt  (o_write_data_cnt),
    .o_wr_busy         (o_wr_busy),
    .o_wr_done         (o_wr_done),
    .o_rd_cycles       (o_rd_cycles),
    .o_wr_cycles       (o_wr_cycles)
  );

  typedef struct {
    logic [10:0] rows;
    logic [15:0] bpr;
    logic [31:0] stride;
    logic [31:0] base;
    int unsigned exp_reqs;
  } rd_vec_t;

  typedef struct {
    logic [15:0] blks;
    logic [17:0] nt;
    logic [31:0] base;
    int unsigned exp_words;
  } wr_vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [17:0] cnt;
  } wr_exp_t;

  logic [31:0] rd_q[$];
  wr_exp_t     wr_q[$];

  int unsigned errors = 0, checks = 0;
  int unsigned rd_req_tot = 0, rd_done_tot = 0, rd_busy_tot = 0;
  int unsigned wr_req_tot = 0, wr_done_tot = 0, wr_busy_tot = 0, wr_word_tot = 0;

  // Read master model: burst completes RD_LAT cycles after each request.
  int rd_timer = -1;
  always @(posedge clk) begin
    #1;
    i_read_done = 1'b0;
    if (rd_timer == 0) i_read_done = 1'b1;
    if (rd_timer >= 0) rd_timer--;
    if (o_ctrl_read) rd_timer = RD_LAT - 1;
  end

  // Write master model: consumes max(num_trans,1) words, then completes.
  int wr_left = -1;
  always @(posedge clk) begin
    #1;
    i_indata_req_wr = 1'b0;
    i_write_done    = 1'b0;
    if (wr_left > 0) begin
      i_indata_req_wr = 1'b1;
      wr_left--;
    end else if (wr_left == 0) begin
      i_write_done = 1'b1;
      wr_left = -1;
    end
    if (o_ctrl_write) wr_left = (i_num_trans == 18'd0) ? 1 : int'(i_num_trans);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: advance to the falling edge and score all DUT activity.
  task automatic tick();
    wr_exp_t e;
    @(negedge clk);
    if (o_rd_busy) rd_busy_tot++;
    if (o_wr_busy) wr_busy_tot++;
    if (o_rd_done) rd_done_tot++;
    if (o_wr_done) wr_done_tot++;
    if (o_ctrl_write) wr_req_tot++;
    if (o_ctrl_read) begin
      rd_req_tot++;
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected_req: got addr 0x%0h expected no request", o_read_addr);
      end else begin
        chk("rd_addr", {32'd0, o_read_addr}, {32'd0, rd_q.pop_front()});
      end
    end
    if (i_indata_req_wr) begin
      wr_word_tot++;
      if (wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_unexpected_word: got addr 0x%0h expected no word", o_write_addr);
      end else begin
        e = wr_q.pop_front();
        chk("wr_addr", {32'd0, o_write_addr}, {32'd0, e.addr});
        chk("wr_cnt", {46'd0, o_write_data_cnt}, {46'd0, e.cnt});
      end
    end
  endtask

  task automatic wait_rd(input int unsigned d0);
    int n = 0;
    while (rd_done_tot == d0 && n < BUDGET) begin tick(); n++; end
    if (rd_done_tot == d0) begin
      checks++; errors++;
      $display("FAIL rd_timeout: got no rd_done expected one within %0d cycles", BUDGET);
    end
  endtask

  task automatic wait_wr(input int unsigned d0);
    int n = 0;
    while (wr_done_tot == d0 && n < BUDGET) begin tick(); n++; end
    if (wr_done_tot == d0) begin
      checks++; errors++;
      $display("FAIL wr_timeout: got no wr_done expected one within %0d cycles", BUDGET);
    end
  endtask

  task automatic load_rd(input rd_vec_t v);
    for (int r = 0; r < int'(v.rows); r++)
      for (int b = 0; b < int'(v.bpr); b++)
        rd_q.push_back(v.base + 32'(r) * v.stride + 32'(b * 64));
    i_rd_num_rows     = v.rows;
    i_rd_blks_per_row = v.bpr;
    i_rd_row_stride   = v.stride;
    i_base_address_rd = v.base;
  endtask

  task automatic load_wr(input wr_vec_t v);
    int words;
    words = (v.nt == 18'd0) ? 1 : int'(v.nt);
    for (int b = 0; b < int'(v.blks); b++)
      for (int w = 0; w < words; w++)
        wr_q.push_back('{v.base + 32'(b * 64) + 32'(w * 4), 18'(w)});
    i_wr_num_blks     = v.blks;
    i_num_trans       = v.nt;
    i_base_address_wr = v.base;
  endtask

  task automatic run_rd(input rd_vec_t v);
    int unsigned r0, d0, b0;
    load_rd(v);
    r0 = rd_req_tot; d0 = rd_done_tot; b0 = rd_busy_tot;
    i_start_rd = 1'b1; tick(); i_start_rd = 1'b0;
    wait_rd(d0);
    repeat (3) tick();
    chk("rd_reqs", 64'(rd_req_tot - r0), 64'(v.exp_reqs));
    chk("rd_done_pulses", 64'(rd_done_tot - d0), 64'd1);
    chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
    chk("rd_idle_after", {63'd0, o_rd_busy}, 64'd0);
`ifdef DMA_SEQ_PERF_EN
    chk("rd_cycles", {32'd0, o_rd_cycles}, 64'(rd_busy_tot - b0));
    repeat (4) tick();
    chk("rd_cycles_hold", {32'd0, o_rd_cycles}, 64'(rd_busy_tot - b0));
`else
    chk("rd_cycles_tied", {32'd0, o_rd_cycles}, 64'd0);
`endif
    rd_q.delete();
  endtask

  task automatic run_wr(input wr_vec_t v);
    int unsigned r0, d0, b0, w0;
    load_wr(v);
    r0 = wr_req_tot; d0 = wr_done_tot; b0 = wr_busy_tot; w0 = wr_word_tot;
    i_start_wr = 1'b1; tick(); i_start_wr = 1'b0;
    wait_wr(d0);
    repeat (3) tick();
    chk("wr_reqs", 64'(wr_req_tot - r0), 64'(v.blks));
    chk("wr_words", 64'(wr_word_tot - w0), 64'(v.exp_words));
    chk("wr_done_pulses", 64'(wr_done_tot - d0), 64'd1);
    chk("wr_cnt_final", {46'd0, o_write_data_cnt}, 64'd0);
    chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
`ifdef DMA_SEQ_PERF_EN
    chk("wr_cycles", {32'd0, o_wr_cycles}, 64'(wr_busy_tot - b0));
`else
    chk("wr_cycles_tied", {32'd0, o_wr_cycles}, 64'd0);
`endif
    wr_q.delete();
  endtask

  rd_vec_t rv[5];
  wr_vec_t wv[5];

  initial begin
    int unsigned r0, d0, d1;
    int n;

    rv[0] = '{11'd2, 16'd3, 32'h0000_0400, 32'h0000_1000, 6};
    rv[1] = '{11'd1, 16'd1, 32'h0000_0000, 32'h0000_0020, 1};
    rv[2] = '{11'd3, 16'd2, 32'h0000_0100, 32'hFFFF_FF80, 6};
    rv[3] = '{11'd0, 16'd4, 32'h0000_0040, 32'h0000_5000, 0};
    rv[4] = '{11'd2, 16'd1, 32'hFFFF_FFC0, 32'h0000_8000, 2};
    wv[0] = '{16'd2, 18'd4, 32'h0000_2000, 8};
    wv[1] = '{16'd1, 18'd1, 32'h0000_3000, 1};
    wv[2] = '{16'd3, 18'd0, 32'h0000_4000, 3};
    wv[3] = '{16'd2, 18'd2, 32'hFFFF_FFC0, 4};
    wv[4] = '{16'd0, 18'd4, 32'h0000_6000, 0};

    rst = 1'b1;
    i_start_rd = 1'b0; i_start_wr = 1'b0;
    i_base_address_rd = '0; i_base_address_wr = '0;
    i_num_trans = '0; i_rd_blks_per_row = '0; i_rd_num_rows = '0;
    i_rd_row_stride = '0; i_wr_num_blks = '0;
    repeat (3) tick();
    chk("rst_ctrl_read", {63'd0, o_ctrl_read}, 64'd0);
    chk("rst_read_addr", {32'd0, o_read_addr}, 64'd0);
    chk("rst_rd_busy", {63'd0, o_rd_busy}, 64'd0);
    chk("rst_rd_done", {63'd0, o_rd_done}, 64'd0);
    chk("rst_ctrl_write", {63'd0, o_ctrl_write}, 64'd0);
    chk("rst_write_addr", {32'd0, o_write_addr}, 64'd0);
    chk("rst_write_cnt", {46'd0, o_write_data_cnt}, 64'd0);
    chk("rst_wr_busy", {63'd0, o_wr_busy}, 64'd0);
    chk("rst_rd_cycles", {32'd0, o_rd_cycles}, 64'd0);
    rst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 5; i++) run_rd(rv[i]);
    for (int i = 0; i < 5; i++) run_wr(wv[i]);

    // Zero-length read: done on the cycle after start, never a request.
    i_rd_num_rows = 11'd2; i_rd_blks_per_row = 16'd0;
    r0 = rd_req_tot;
    i_start_rd = 1'b1; tick(); i_start_rd = 1'b0;
    chk("zl_done_next", {63'd0, o_rd_done}, 64'd1);
    chk("zl_busy", {63'd0, o_rd_busy}, 64'd1);
    tick();
    chk("zl_done_one_cycle", {63'd0, o_rd_done}, 64'd0);
    chk("zl_no_req", 64'(rd_req_tot - r0), 64'd0);

    // Start while busy must not relatch or restart.
    load_rd(rv[0]);
    r0 = rd_req_tot; d0 = rd_done_tot;
    i_start_rd = 1'b1; tick(); i_start_rd = 1'b0;
    repeat (10) tick();
    i_rd_blks_per_row = 16'd5; i_base_address_rd = 32'h0000_9000;
    i_start_rd = 1'b1; tick(); i_start_rd = 1'b0;
    wait_rd(d0);
    repeat (3) tick();
    chk("busy_start_reqs", 64'(rd_req_tot - r0), 64'd6);
    chk("busy_start_dones", 64'(rd_done_tot - d0), 64'd1);
    rd_q.delete();

    // Both sides launched together.
    load_rd(rv[0]); load_wr(wv[0]);
    d0 = rd_done_tot; d1 = wr_done_tot; r0 = rd_req_tot;
    i_start_rd = 1'b1; i_start_wr = 1'b1; tick();
    i_start_rd = 1'b0; i_start_wr = 1'b0;
    wait_rd(d0); wait_wr(d1);
    repeat (3) tick();
    chk("dual_rd_reqs", 64'(rd_req_tot - r0), 64'd6);
    chk("dual_wr_done", 64'(wr_done_tot - d1), 64'd1);
    chk("dual_wr_q", 64'(wr_q.size()), 64'd0);
    rd_q.delete(); wr_q.delete();

    // Reset while waiting on block 3 aborts; a late read_done in IDLE is ignored.
    load_rd(rv[0]);
    r0 = rd_req_tot; d0 = rd_done_tot;
    i_start_rd = 1'b1; tick(); i_start_rd = 1'b0;
    n = 0;
    while (rd_req_tot - r0 < 3 && n < BUDGET) begin tick(); n++; end
    chk("abort_reached_blk3", 64'(rd_req_tot - r0), 64'd3);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("abort_ctrl_read", {63'd0, o_ctrl_read}, 64'd0);
    chk("abort_read_addr", {32'd0, o_read_addr}, 64'd0);
    chk("abort_rd_busy", {63'd0, o_rd_busy}, 64'd0);
    chk("abort_rd_cycles", {32'd0, o_rd_cycles}, 64'd0);
    rst = 1'b0;
    rd_q.delete();
    repeat (10) tick();
    chk("abort_no_done", 64'(rd_done_tot - d0), 64'd0);
    chk("abort_still_idle", {63'd0, o_rd_busy}, 64'd0);
    run_rd(rv[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
